seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 180 ++++++++++++++++++
 tb/tb_seq_divider.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
//   state_e         : controller states
//   calc_steps()    : number of CALC clocks for a given width / bits-per-clock
//   cnt_width()     : width of the step counter that must hold calc_steps()
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int calc_steps(input int dividend_w, input int steps_per_cycle);
    return dividend_w / steps_per_cycle;
  endfunction

  function automatic int cnt_width(input int dividend_w, input int steps_per_cycle);
    return $clog2(dividend_w / steps_per_cycle + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem_in  : partial remainder before the step (DIVISOR_W+1 bits)
//   dvs     : divisor magnitude
//   bit_in  : next dividend bit, MSB first
//   rem_out : partial remainder after the step
//   q_bit   : resolved quotient bit
module div_step #(
  parameter int DIVISOR_W = 10
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic [DIVISOR_W-1:0] dvs,
  input  logic                 bit_in,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  // Shifted value carries one guard bit so the comparison never overflows.
  logic [DIVISOR_W+1:0] shifted;

  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {2'b00, dvs});
    rem_out = q_bit ? (DIVISOR_W+1)'(shifted - {2'b00, dvs}) : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider with signed mode, divide-by-zero
// detection and valid/ready handshakes on both sides.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (in_ready only in IDLE)
//   dividend, divisor     : operands, sampled on the accepting edge
//   signed_mode           : 1 = two's complement operands and results
//   out_valid / out_ready : result handshake (out_valid only in DONE)
//   quotient, remainder   : result, held stable while out_valid
//   div_by_zero           : divisor was zero for this result
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | STEPS_PER_CYCLE restoring steps per clock
// FIX   | sign correction, result registers loaded
// DONE  | result presented until out_ready
module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W      = 20,
  parameter int DIVISOR_W       = 10,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  input  logic                  signed_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int N  = calc_steps(DIVIDEND_W, STEPS_PER_CYCLE);
  localparam int CW = cnt_width(DIVIDEND_W, STEPS_PER_CYCLE);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  state_e                state_q, state_d;
  logic                  sgn_q, sgn_d;
  logic                  dvd_neg_q, dvd_neg_d;
  logic                  dvs_neg_q, dvs_neg_d;
  logic                  dbz_q, dbz_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  // Dividend magnitude shifts out of the top while quotient bits shift in below.
  logic [DIVIDEND_W-1:0] dq_q, dq_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  div_by_zero_q, div_by_zero_d;

  logic [DIVISOR_W:0]    rem_step;
  logic [DIVIDEND_W-1:0] dq_step;

  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    logic [DIVISOR_W:0]    r_in, r_out;
    logic [DIVIDEND_W-1:0] d_in, d_out;
    logic                  qb;

    if (i == 0) begin : g_first
      assign r_in = rem_q;
      assign d_in = dq_q;
    end else begin : g_next
      assign r_in = g_step[i-1].r_out;
      assign d_in = g_step[i-1].d_out;
    end

    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
      .rem_in  (r_in),
      .dvs     (dvs_q),
      .bit_in  (d_in[DIVIDEND_W-1]),
      .rem_out (r_out),
      .q_bit   (qb)
    );

    assign d_out = {d_in[DIVIDEND_W-2:0], qb};
  end

  assign rem_step = g_step[STEPS_PER_CYCLE-1].r_out;
  assign dq_step  = g_step[STEPS_PER_CYCLE-1].d_out;

  always_comb begin
    state_d       = state_q;
    sgn_d         = sgn_q;
    dvd_neg_d     = dvd_neg_q;
    dvs_neg_d     = dvs_neg_q;
    dbz_d         = dbz_q;
    cnt_d         = cnt_q;
    dq_d          = dq_q;
    dvs_d         = dvs_q;
    rem_d         = rem_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sgn_d     = signed_mode;
          dvd_neg_d = signed_mode & dividend[DIVIDEND_W-1];
          dvs_neg_d = signed_mode & divisor[DIVISOR_W-1];
          dq_d      = (signed_mode & dividend[DIVIDEND_W-1]) ? -dividend : dividend;
          dvs_d     = (signed_mode & divisor[DIVISOR_W-1])   ? -divisor  : divisor;
          rem_d     = '0;
          cnt_d     = '0;
          dbz_d     = (divisor == '0);
          state_d   = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        rem_d = rem_step;
        dq_d  = dq_step;
        cnt_d = cnt_q + 1'b1;
        // Leaves the counter at N, which FIX reads as "no settle cycle needed".
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        if (dbz_q && (cnt_q == '0)) begin
          // Divide-by-zero arrives with a zero counter; hold one clock so the
          // short path presents its result two edges after accept.
          cnt_d = CW'(1);
        end else begin
          if (dbz_q) begin
            quotient_d  = '1;
            remainder_d = '0;
          end else begin
            quotient_d  = (sgn_q & (dvd_neg_q ^ dvs_neg_q)) ? -dq_q : dq_q;
            remainder_d = dvd_neg_q ? DIVISOR_W'(-rem_q) : DIVISOR_W'(rem_q);
          end
          div_by_zero_d = dbz_q;
          state_d       = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sgn_q         <= 1'b0;
      dvd_neg_q     <= 1'b0;
      dvs_neg_q     <= 1'b0;
      dbz_q         <= 1'b0;
      cnt_q         <= '0;
      dq_q          <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sgn_q         <= sgn_d;
      dvd_neg_q     <= dvd_neg_d;
      dvs_neg_q     <= dvs_neg_d;
      dbz_q         <= dbz_d;
      cnt_q         <= cnt_d;
      dq_q          <= dq_d;
      dvs_q         <= dvs_d;
      rem_q         <= rem_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        signed_mode = 1'b0;
  logic [19:0] dividend = '0;
  logic [9:0]  divisor = '0;

  logic        a_in_ready, a_out_valid, a_dbz;
  logic [19:0] a_q;
  logic [9:0]  a_r;
  logic        b_in_ready, b_out_valid, b_dbz;
  logic [19:0] b_q;
  logic [9:0]  b_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.DIVIDEND_W(20), .DIVISOR_W(10), .STEPS_PER_CYCLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
    .out_valid(a_out_valid), .out_ready(out_ready), .quotient(a_q),
    .remainder(a_r), .div_by_zero(a_dbz)
  );

  seq_divider #(.DIVIDEND_W(20), .DIVISOR_W(10), .STEPS_PER_CYCLE(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
    .out_valid(b_out_valid), .out_ready(out_ready), .quotient(b_q),
    .remainder(b_r), .div_by_zero(b_dbz)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, truncating toward zero in signed mode.
  function automatic void model(input logic [19:0] a, input logic [9:0] b, input logic sm,
                                output logic [19:0] q, output logic [9:0] r, output logic z);
    longint sa, sb, qq, rr;
    if (b == 10'd0) begin
      q = 20'hFFFFF; r = 10'd0; z = 1'b1;
    end else begin
      if (sm) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      qq = sa / sb;
      rr = sa % sb;
      q = qq[19:0];
      r = rr[9:0];
      z = 1'b0;
    end
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(a_in_ready && b_in_ready) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", {31'd0, a_in_ready && b_in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [19:0] a, input logic [9:0] b, input logic sm);
    logic [19:0] eq; logic [9:0] er; logic ez;
    int lat_a, lat_b, exp_a, exp_b;
    logic [19:0] cq_a, cq_b; logic [9:0] cr_a, cr_b; logic cz_a, cz_b;
    model(a, b, sm, eq, er, ez);
    exp_a = ez ? 2 : 21;
    exp_b = ez ? 2 : 6;
    lat_a = 0; lat_b = 0;
    cq_a = 'x; cq_b = 'x; cr_a = 'x; cr_b = 'x; cz_a = 'x; cz_b = 'x;
    @(negedge clk);
    wait_idle();
    dividend = a; divisor = b; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 20'($urandom);
    divisor = 10'($urandom);
    signed_mode = 1'($urandom);
    for (int k = 1; k <= 100 && (lat_a == 0 || lat_b == 0); k++) begin
      @(posedge clk);
      #1;
      if (lat_a == 0 && a_out_valid) begin lat_a = k; cq_a = a_q; cr_a = a_r; cz_a = a_dbz; end
      if (lat_b == 0 && b_out_valid) begin lat_b = k; cq_b = b_q; cr_b = b_r; cz_b = b_dbz; end
    end
    check("lat_a", lat_a, exp_a);
    check("lat_b", lat_b, exp_b);
    check("quot_a", {12'd0, cq_a}, {12'd0, eq});
    check("rem_a", {22'd0, cr_a}, {22'd0, er});
    check("dbz_a", {31'd0, cz_a}, {31'd0, ez});
    check("quot_b", {12'd0, cq_b}, {12'd0, eq});
    check("rem_b", {22'd0, cr_b}, {22'd0, er});
    check("dbz_b", {31'd0, cz_b}, {31'd0, ez});
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] eq; logic [9:0] er; logic ez;
    logic [19:0] ra; logic [9:0] rb;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_quot", {12'd0, a_q}, 32'd0);
    check("rst_rem", {22'd0, a_r}, 32'd0);
    check("rst_dbz", {31'd0, a_dbz}, 32'd0);
    check("rst_out_valid_b", {31'd0, b_out_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(20'd1000, 10'd7, 1'b0);
    run_op(20'hFFC18, 10'd7, 1'b1);          // -1000 / 7
    run_op(20'd1000, 10'h3F9, 1'b1);         // 1000 / -7
    run_op(20'd55, 10'd0, 1'b0);
    run_op(20'd55, 10'd0, 1'b1);
    run_op(20'hFFFFF, 10'h3FF, 1'b0);
    run_op(20'h80000, 10'h3FF, 1'b1);        // signed overflow
    run_op(20'h80000, 10'h200, 1'b1);        // most negative / most negative
    run_op(20'd5, 10'd9, 1'b0);              // dividend < divisor

    // Randomized cases
    for (int i = 0; i < 24; i++) begin
      ra = 20'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    // Back-pressure: hold out_ready low in DONE, in_valid must be ignored
    @(negedge clk);
    wait_idle();
    model(20'd12345, 10'd67, 1'b0, eq, er, ez);
    dividend = 20'd12345; divisor = 10'd67; signed_mode = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (25) @(negedge clk);
    dividend = 20'd99; divisor = 10'd3; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, a_out_valid}, 32'd1);
      check("hold_ready", {31'd0, a_in_ready}, 32'd0);
      check("hold_quot", {12'd0, a_q}, {12'd0, eq});
      check("hold_rem", {22'd0, a_r}, {22'd0, er});
      check("hold_quot_b", {12'd0, b_q}, {12'd0, eq});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_ready", {31'd0, a_in_ready}, 32'd1);
    check("release_valid", {31'd0, a_out_valid}, 32'd0);
    check("release_ready_b", {31'd0, b_in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("no_extra_op", {31'd0, a_in_ready}, 32'd1);

    // Reset in the middle of CALC
    @(negedge clk);
    dividend = 20'd1000; divisor = 10'd7; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_calc_busy", {31'd0, a_in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, a_out_valid}, 32'd0);
    check("abort_ready", {31'd0, a_in_ready}, 32'd1);
    check("abort_quot", {12'd0, a_q}, 32'd0);
    check("abort_ready_b", {31'd0, b_in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(20'd100, 10'd9, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
